// File: rtl/regfile_hilo_if.sv
// Read/write bus bundle between the pipeline (master) and the architectural
// register file with HI/LO (slave).
interface regfile_hilo_if;
  logic [37:0] wb_to_rf_bus;
  logic [65:0] hilo_wb_to_rf_bus;
  logic [37:0] ex_rf_bus;
  logic [37:0] mem_rf_bus;
  logic [65:0] ex_hilo_bus;
  logic [65:0] mem_hilo_bus;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  modport master (
    output wb_to_rf_bus, hilo_wb_to_rf_bus, ex_rf_bus, mem_rf_bus,
    output ex_hilo_bus, mem_hilo_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_rdata, lo_rdata
  );

  modport slave (
    input  wb_to_rf_bus, hilo_wb_to_rf_bus, ex_rf_bus, mem_rf_bus,
    input  ex_hilo_bus, mem_hilo_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/regfile_hilo.sv
// 32x32 GPR file plus HI/LO, committed from WB, with combinational ID reads.
// Define RF_BYPASS_EN to forward EX/MEM/WB pending writes onto the read ports.
module regfile_hilo (
  input logic          clk,
  input logic          rst,
  regfile_hilo_if.slave bus
);

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_hi_we, wb_lo_we;
  logic [31:0] wb_hi_wdata, wb_lo_wdata;

  assign wb_we       = bus.wb_to_rf_bus[37];
  assign wb_waddr    = bus.wb_to_rf_bus[36:32];
  assign wb_wdata    = bus.wb_to_rf_bus[31:0];
  assign wb_hi_wdata = bus.hilo_wb_to_rf_bus[65:34];
  assign wb_lo_wdata = bus.hilo_wb_to_rf_bus[33:2];
  assign wb_hi_we    = bus.hilo_wb_to_rf_bus[1];
  assign wb_lo_we    = bus.hilo_wb_to_rf_bus[0];

  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (wb_we && (wb_waddr != 5'd0)) gpr_d[wb_waddr] = wb_wdata;
    if (wb_hi_we) hi_d = wb_hi_wdata;
    if (wb_lo_we) lo_d = wb_lo_wdata;
    // $0 is hardwired; its flop is constant and gets swept away
    gpr_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

`ifdef RF_BYPASS_EN
  // Youngest in-flight writer wins: EX, then MEM, then WB, then storage.
  function automatic logic [31:0] resolve_gpr(
    input logic [4:0]  addr,
    input logic [37:0] ex_b,
    input logic [37:0] mem_b,
    input logic [37:0] wb_b,
    input logic [31:0] stored
  );
    logic [31:0] v;
    if (addr == 5'd0)                            v = '0;
    else if (ex_b[37]  && ex_b[36:32]  == addr)  v = ex_b[31:0];
    else if (mem_b[37] && mem_b[36:32] == addr)  v = mem_b[31:0];
    else if (wb_b[37]  && wb_b[36:32]  == addr)  v = wb_b[31:0];
    else                                         v = stored;
    return v;
  endfunction

  function automatic logic [31:0] resolve_half(
    input logic        ex_we,
    input logic [31:0] ex_d,
    input logic        mem_we,
    input logic [31:0] mem_d,
    input logic        wb_we_i,
    input logic [31:0] wb_d,
    input logic [31:0] stored
  );
    logic [31:0] v;
    if (ex_we)        v = ex_d;
    else if (mem_we)  v = mem_d;
    else if (wb_we_i) v = wb_d;
    else              v = stored;
    return v;
  endfunction

  always_comb begin
    bus.rdata1   = '0;
    bus.rdata2   = '0;
    bus.hi_rdata = '0;
    bus.lo_rdata = '0;
    if (!rst) begin
      bus.rdata1 = resolve_gpr(bus.raddr1, bus.ex_rf_bus, bus.mem_rf_bus,
                               bus.wb_to_rf_bus, gpr_q[bus.raddr1]);
      bus.rdata2 = resolve_gpr(bus.raddr2, bus.ex_rf_bus, bus.mem_rf_bus,
                               bus.wb_to_rf_bus, gpr_q[bus.raddr2]);
      bus.hi_rdata = resolve_half(bus.ex_hilo_bus[1], bus.ex_hilo_bus[65:34],
                                  bus.mem_hilo_bus[1], bus.mem_hilo_bus[65:34],
                                  wb_hi_we, wb_hi_wdata, hi_q);
      bus.lo_rdata = resolve_half(bus.ex_hilo_bus[0], bus.ex_hilo_bus[33:2],
                                  bus.mem_hilo_bus[0], bus.mem_hilo_bus[33:2],
                                  wb_lo_we, wb_lo_wdata, lo_q);
    end
  end
`else
  // Storage-only reads: ID must stall on RAW hazards against EX/MEM/WB.
  always_comb begin
    bus.rdata1   = '0;
    bus.rdata2   = '0;
    bus.hi_rdata = '0;
    bus.lo_rdata = '0;
    if (!rst) begin
      bus.rdata1   = gpr_q[bus.raddr1];
      bus.rdata2   = gpr_q[bus.raddr2];
      bus.hi_rdata = hi_q;
      bus.lo_rdata = lo_q;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo against a queue-based architectural
// model; follows RF_BYPASS_EN the same way the design does.
module tb_regfile_hilo;
  logic clk;
  logic rst;
  regfile_hilo_if bus_if ();

  regfile_hilo dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  function automatic logic [37:0] mk_rf(input logic we, input logic [4:0] a,
                                        input logic [31:0] d);
    return {we, a, d};
  endfunction

  function automatic logic [65:0] mk_hl(input logic hwe, input logic [31:0] h,
                                        input logic lwe, input logic [31:0] l);
    return {h, l, hwe, lwe};
  endfunction

  // Expected GPR read: pending writers listed youngest-first, first hit wins.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [37:0] pend [$];
    if (rst || a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    pend.push_back(bus_if.ex_rf_bus);
    pend.push_back(bus_if.mem_rf_bus);
    pend.push_back(bus_if.wb_to_rf_bus);
    foreach (pend[k])
      if (pend[k][37] && pend[k][36:32] == a) return pend[k][31:0];
`endif
    return m_gpr[a];
  endfunction

  // sel=1 for HI, 0 for LO
  function automatic logic [31:0] exp_half(input bit sel);
    logic [65:0] pend [$];
    if (rst) return 32'd0;
`ifdef RF_BYPASS_EN
    pend.push_back(bus_if.ex_hilo_bus);
    pend.push_back(bus_if.mem_hilo_bus);
    pend.push_back(bus_if.hilo_wb_to_rf_bus);
    foreach (pend[k]) begin
      if (sel && pend[k][1])  return pend[k][65:34];
      if (!sel && pend[k][0]) return pend[k][33:2];
    end
`endif
    return sel ? m_hi : m_lo;
  endfunction

  task automatic idle();
    bus_if.wb_to_rf_bus      = '0;
    bus_if.hilo_wb_to_rf_bus = '0;
    bus_if.ex_rf_bus         = '0;
    bus_if.mem_rf_bus        = '0;
    bus_if.ex_hilo_bus       = '0;
    bus_if.mem_hilo_bus      = '0;
  endtask

  // Advance one clock, committing the WB buses into the model; returns at negedge+2.
  task automatic cycle();
    logic        r;
    logic [37:0] w;
    logic [65:0] h;
    r = rst; w = bus_if.wb_to_rf_bus; h = bus_if.hilo_wb_to_rf_bus;
    @(posedge clk);
    if (r) begin
      foreach (m_gpr[i]) m_gpr[i] = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      if (w[37] && w[36:32] != 5'd0) m_gpr[w[36:32]] = w[31:0];
      if (h[1]) m_hi = h[65:34];
      if (h[0]) m_lo = h[33:2];
    end
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    bus_if.ex_rf_bus   = mk_rf(1'b1, 5'd4, 32'hCAFE_0004);
    bus_if.ex_hilo_bus = mk_hl(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222);
    bus_if.raddr1 = 5'd4; bus_if.raddr2 = 5'd4;
    #1;
    total++;
    if (bus_if.rdata1 !== 32'd0 || bus_if.hi_rdata !== 32'd0 || bus_if.lo_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_force: rd1=%h hi=%h lo=%h want all 0",
               bus_if.rdata1, bus_if.hi_rdata, bus_if.lo_rdata);
    end
    cycle();
    rst = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      bus_if.raddr1 = a[4:0]; bus_if.raddr2 = 5'(31 - a);
      #1;
      total++;
      if (bus_if.rdata1 !== 32'd0 || bus_if.rdata2 !== 32'd0) begin
        bad++;
        $display("FAIL reset_read a=%0d: rd1=%h rd2=%h want 0", a, bus_if.rdata1, bus_if.rdata2);
      end
    end
    total++;
    if (bus_if.hi_rdata !== 32'd0 || bus_if.lo_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_hilo: hi=%h lo=%h want 0", bus_if.hi_rdata, bus_if.lo_rdata);
    end
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd0, 32'hDEAD_BEEF);
    bus_if.raddr1 = 5'd0;
    #1;
    total++;
    if (bus_if.rdata1 !== 32'd0) begin
      bad++; $display("FAIL zero_same: got %h want 0", bus_if.rdata1);
    end
    cycle();
    idle();
    #1;
    e = exp_rd(5'd0);
    total++;
    if (bus_if.rdata1 !== e || e !== 32'd0) begin
      bad++; $display("FAIL zero_next: got %h want 0", bus_if.rdata1);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd5, 32'h1234_5678);
    bus_if.raddr1 = 5'd5;
    #1;
`ifdef RF_BYPASS_EN
    e = 32'h1234_5678;
`else
    e = 32'd0;
`endif
    total++;
    if (bus_if.rdata1 !== e || exp_rd(5'd5) !== e) begin
      bad++; $display("FAIL basic_same: got %h want %h", bus_if.rdata1, e);
    end
    cycle();
    idle();
    #1;
    total++;
    if (bus_if.rdata1 !== 32'h1234_5678) begin
      bad++; $display("FAIL basic_next: got %h want 12345678", bus_if.rdata1);
    end
  endtask

  task automatic test_priority();
    logic [31:0] e;
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd7, 32'd1);
    cycle();
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd7, 32'd2);
    bus_if.mem_rf_bus   = mk_rf(1'b1, 5'd7, 32'd3);
    bus_if.ex_rf_bus    = mk_rf(1'b1, 5'd7, 32'd4);
    bus_if.raddr2 = 5'd7;
    for (int step = 0; step < 3; step++) begin
      #1;
`ifdef RF_BYPASS_EN
      e = 32'(4 - step);
`else
      e = 32'd1;
`endif
      total++;
      if (bus_if.rdata2 !== e || exp_rd(5'd7) !== e) begin
        bad++; $display("FAIL prio step=%0d: got %h want %h", step, bus_if.rdata2, e);
      end
      if (step == 0) bus_if.ex_rf_bus = '0;
      if (step == 1) bus_if.mem_rf_bus = '0;
    end
    cycle();
    idle();
    #1;
    total++;
    if (bus_if.rdata2 !== 32'd2) begin
      bad++; $display("FAIL prio_commit: got %h want 2", bus_if.rdata2);
    end
  endtask

  task automatic test_hilo();
    logic [31:0] old_lo, e;
    bus_if.hilo_wb_to_rf_bus = mk_hl(1'b1, 32'h3333_3333, 1'b1, 32'h7777);
    cycle();
    old_lo = 32'h7777;
    bus_if.hilo_wb_to_rf_bus = mk_hl(1'b1, 32'hAAAA_0000, 1'b0, 32'h5555);
    cycle();
    idle();
    #1;
    total++;
    if (bus_if.hi_rdata !== 32'hAAAA_0000 || bus_if.lo_rdata !== old_lo) begin
      bad++;
      $display("FAIL hilo_indep: hi=%h lo=%h want aaaa0000/%h",
               bus_if.hi_rdata, bus_if.lo_rdata, old_lo);
    end
    bus_if.ex_hilo_bus = mk_hl(1'b0, 32'hFFFF_FFFF, 1'b1, 32'h11);
    #1;
`ifdef RF_BYPASS_EN
    e = 32'h11;
`else
    e = old_lo;
`endif
    total++;
    if (bus_if.lo_rdata !== e || bus_if.hi_rdata !== 32'hAAAA_0000) begin
      bad++;
      $display("FAIL hilo_ex_lo: hi=%h lo=%h want aaaa0000/%h",
               bus_if.hi_rdata, bus_if.lo_rdata, e);
    end
    idle();
  endtask

  task automatic test_reset_collision();
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd3, 32'h55);
    cycle();
    rst = 1'b1;
    bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd3, 32'hFF);
    bus_if.ex_rf_bus    = mk_rf(1'b1, 5'd3, 32'h9);
    bus_if.raddr1 = 5'd3;
    #1;
    total++;
    if (bus_if.rdata1 !== 32'd0) begin
      bad++; $display("FAIL rst_ex_force: got %h want 0", bus_if.rdata1);
    end
    cycle();
    rst = 1'b0;
    idle();
    bus_if.raddr2 = 5'd7;
    #1;
    total++;
    if (bus_if.rdata1 !== 32'd0 || bus_if.rdata2 !== 32'd0 || bus_if.hi_rdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_collide: r3=%h r7=%h hi=%h want 0",
               bus_if.rdata1, bus_if.rdata2, bus_if.hi_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bus_if.raddr1 = 5'd12;
    bus_if.raddr2 = 5'd12;
    for (int i = 0; i < 6; i++) begin
      bus_if.wb_to_rf_bus = mk_rf(1'b1, 5'd12, $urandom);
      #1;
      e = exp_rd(5'd12);
      total++;
      if (bus_if.rdata1 !== e || bus_if.rdata2 !== e) begin
        bad++; $display("FAIL b2b i=%0d: rd1=%h rd2=%h want %h", i, bus_if.rdata1, bus_if.rdata2, e);
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, eh, el;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus_if.wb_to_rf_bus = mk_rf($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      bus_if.mem_rf_bus   = mk_rf($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      bus_if.ex_rf_bus    = mk_rf($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      bus_if.hilo_wb_to_rf_bus = mk_hl($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom);
      bus_if.mem_hilo_bus      = mk_hl($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom);
      bus_if.ex_hilo_bus       = mk_hl($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom);
      bus_if.raddr1 = 5'($urandom_range(0, 8));
      bus_if.raddr2 = 5'($urandom_range(0, 8));
      #1;
      e1 = exp_rd(bus_if.raddr1);
      e2 = exp_rd(bus_if.raddr2);
      eh = exp_half(1'b1);
      el = exp_half(1'b0);
      total++;
      if (bus_if.rdata1 !== e1 || bus_if.rdata2 !== e2 ||
          bus_if.hi_rdata !== eh || bus_if.lo_rdata !== el) begin
        bad++;
        $display("FAIL rand i=%0d: rd1=%h/%h rd2=%h/%h hi=%h/%h lo=%h/%h (got/want)", i,
                 bus_if.rdata1, e1, bus_if.rdata2, e2, bus_if.hi_rdata, eh, bus_if.lo_rdata, el);
      end
      cycle();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    foreach (m_gpr[i]) m_gpr[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst = 1'b1;
    idle();
    bus_if.raddr1 = '0; bus_if.raddr2 = '0;
    @(negedge clk);
    #2;
    test_reset();
    test_basic();
    test_priority();
    test_hilo();
    test_reset_collision();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
